// File: rtl/mem_arbiter_if.sv
// Bundle between the arbiter, its two requesters (fetch, data) and the shared memory.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // fetch requester
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  // data requester
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  // memory bus
  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  // hazard unit
  logic          stall_if;
  logic          stall_dm;

  // arbiter view
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output mem_valid, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
  );

  // environment view: requesters plus memory
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  mem_valid, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported memory, with a bounded data-first
// priority so that a waiting fetch is never starved beyond STARVE_LIMIT grants.
module mem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  state_e        state_q,     state_d;
  logic [SW-1:0] streak_q,    streak_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          if_ready_c;
  logic          dm_ready_c;
  logic          dm_wins_c;

  // Data has priority unless the fetch has already waited LIMIT data grants.
  assign dm_wins_c = bus.dm_req && ((streak_q < LIMIT) || !bus.if_req);

  // Completion is the memory handshake seen from the granted side only.
  assign if_ready_c = (state_q == BUSY_IF) && bus.mem_ready;
  assign dm_ready_c = (state_q == BUSY_DM) && bus.mem_ready;

  // State register and latched memory request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Arbitration, grant latching and completion.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        mem_valid_d = 1'b0;
        mem_we_d    = 1'b0;
        if (!bus.if_req) begin
          streak_d = '0;
        end
        if (dm_wins_c) begin
          state_d     = BUSY_DM;
          mem_valid_d = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          if (bus.if_req && (streak_q < LIMIT)) begin
            streak_d = streak_q + SW'(1);
          end
        end else if (bus.if_req) begin
          state_d     = BUSY_IF;
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          streak_d    = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (bus.mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          mem_we_d    = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
        mem_we_d    = 1'b0;
      end
    endcase
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.if_ready  = if_ready_c;
  assign bus.dm_ready  = dm_ready_c;
  assign bus.if_rdata  = if_ready_c ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = dm_ready_c ? bus.mem_rdata : '0;

  assign bus.stall_if  = bus.if_req && !if_ready_c;
  assign bus.stall_dm  = bus.dm_req && !dm_ready_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic reset;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the transaction currently on the memory bus, if any.
  typedef enum int {NONE, FETCH, DATA} kind_e;
  kind_e         m_kind;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  int            m_streak;   // data grants taken while a fetch was waiting
  bit            done_if, done_dm, in_rst;
  int            resets_left;

  // Apply one clock edge to the model using the inputs seen at that edge.
  task automatic model_edge();
    done_if = 0;
    done_dm = 0;
    if (m_kind != NONE) begin
      if (bus.mem_ready) begin
        done_if = (m_kind == FETCH);
        done_dm = (m_kind == DATA);
        m_kind  = NONE;
      end
    end else if (bus.dm_req && (m_streak < int'(LIMIT) || !bus.if_req)) begin
      m_kind  = DATA;
      m_addr  = bus.dm_addr;
      m_we    = bus.dm_we;
      m_wdata = bus.dm_wdata;
      m_streak = bus.if_req ? ((m_streak + 1 > int'(LIMIT)) ? int'(LIMIT) : m_streak + 1) : 0;
    end else if (bus.if_req) begin
      m_kind   = FETCH;
      m_addr   = bus.if_addr;
      m_streak = 0;
    end else begin
      m_streak = 0;
    end
  endtask

  task automatic check_outputs();
    bit exp_if_rdy, exp_dm_rdy;
    exp_if_rdy = (m_kind == FETCH) && bus.mem_ready;
    exp_dm_rdy = (m_kind == DATA) && bus.mem_ready;
    chk("mem_valid", bus.mem_valid, m_kind != NONE);
    chk("mem_we", bus.mem_we, (m_kind == DATA) && m_we);
    if (m_kind != NONE) chk("mem_addr", bus.mem_addr, m_addr);
    if (m_kind == DATA) chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("if_ready", bus.if_ready, exp_if_rdy);
    chk("dm_ready", bus.dm_ready, exp_dm_rdy);
    chk("if_rdata", bus.if_rdata, exp_if_rdy ? bus.mem_rdata : '0);
    chk("dm_rdata", bus.dm_rdata, exp_dm_rdy ? bus.mem_rdata : '0);
    chk("stall_if", bus.stall_if, bus.if_req && !exp_if_rdy);
    chk("stall_dm", bus.stall_dm, bus.dm_req && !exp_dm_rdy);
  endtask

  // Random requesters and memory; requests are held until completion or flushed once granted.
  task automatic drive(input int unsigned pq, input int unsigned pr);
    if (bus.if_req) begin
      if (done_if) begin
        bus.if_req = ($urandom_range(99) < pq);
        bus.if_addr = $urandom;
      end else if (m_kind == FETCH) begin
        bus.if_addr = $urandom;
        if ($urandom_range(99) < 3) bus.if_req = 1'b0;
      end
    end else if (m_kind != FETCH && $urandom_range(99) < pq) begin
      bus.if_req  = 1'b1;
      bus.if_addr = $urandom;
    end

    if (bus.dm_req) begin
      if (done_dm) begin
        bus.dm_req   = ($urandom_range(99) < pq);
        bus.dm_we    = 1'($urandom_range(1));
        bus.dm_addr  = $urandom;
        bus.dm_wdata = $urandom;
      end else if (m_kind == DATA) begin
        bus.dm_we    = 1'($urandom_range(1));
        bus.dm_addr  = $urandom;
        bus.dm_wdata = $urandom;
        if ($urandom_range(99) < 3) bus.dm_req = 1'b0;
      end
    end else if (m_kind != DATA && $urandom_range(99) < pq) begin
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'($urandom_range(1));
      bus.dm_addr  = $urandom;
      bus.dm_wdata = $urandom;
    end

    bus.mem_ready = ($urandom_range(99) < pr);
    bus.mem_rdata = $urandom;
  endtask

  // One cycle: check at negedge, optional async reset, model edge, new inputs.
  task automatic step(input bit rnd, input int unsigned pq, input int unsigned pr);
    @(negedge clk);
    check_outputs();
    if (rnd && resets_left > 0 && m_kind == DATA && !bus.mem_ready && $urandom_range(9) == 0) begin
      #2 reset = 1'b0;
      #1;
      chk("rst_mem_valid", bus.mem_valid, 1'b0);
      chk("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_dm_ready", bus.dm_ready, 1'b0);
      m_kind   = NONE;
      m_streak = 0;
      in_rst   = 1;
      resets_left--;
    end
    @(posedge clk);
    if (in_rst) begin
      done_if = 0;
      done_dm = 0;
    end else begin
      model_edge();
    end
    #1;
    if (in_rst) begin
      reset         = 1'b1;
      in_rst        = 0;
      bus.dm_req    = 1'b0;
      bus.if_req    = 1'b1;
      bus.if_addr   = $urandom;
      bus.mem_ready = ($urandom_range(99) < pr);
      bus.mem_rdata = $urandom;
    end else if (rnd) begin
      drive(pq, pr);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.if_req = 1'b0;  bus.if_addr = '0;
    bus.dm_req = 1'b0;  bus.dm_we = 1'b0;  bus.dm_addr = '0;  bus.dm_wdata = '0;
    bus.mem_ready = 1'b0;  bus.mem_rdata = '0;
    m_kind = NONE;  m_addr = '0;  m_we = 1'b0;  m_wdata = '0;  m_streak = 0;
    done_if = 0;  done_dm = 0;  in_rst = 0;  resets_left = 4;

    #1 reset = 1'b0;
    #2;
    chk("reset_mem_valid", bus.mem_valid, 1'b0);
    chk("reset_mem_we", bus.mem_we, 1'b0);
    chk("reset_mem_addr", bus.mem_addr, '0);
    chk("reset_mem_wdata", bus.mem_wdata, '0);
    chk("reset_if_ready", bus.if_ready, 1'b0);
    chk("reset_dm_ready", bus.dm_ready, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Single zero-wait fetch.
    bus.if_req = 1'b1;  bus.if_addr = 32'h100;
    bus.mem_ready = 1'b1;  bus.mem_rdata = 32'h00500093;
    step(0, 0, 0);
    @(negedge clk);
    check_outputs();
    chk("ex_fetch_addr", bus.mem_addr, 64'h100);
    chk("ex_fetch_rdata", bus.if_rdata, 64'h00500093);
    @(posedge clk);
    model_edge();
    #1 bus.if_req = 1'b0;  bus.mem_ready = 1'b0;

    // Data write with three wait states.
    bus.dm_req = 1'b1;  bus.dm_we = 1'b1;  bus.dm_addr = 32'h2004;  bus.dm_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    bus.mem_ready = 1'b1;
    step(0, 0, 0);
    bus.dm_req = 1'b0;  bus.mem_ready = 1'b0;
    step(0, 0, 0);

    for (int i = 0; i < 1200; i++) step(1, 50, 50);
    for (int i = 0; i < 300;  i++) step(1, 100, 100);
    for (int i = 0; i < 600;  i++) step(1, 70, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported instruction/data memory between the pipeline's fetch stage (PCF/InstrF) and memory stage (ALUResultM/WriteDataM/ReadDataM).
- Grants one requester at a time and drives a valid/ready memory bus.
- Returns read data and a one-cycle completion strobe to the granted requester.
- Produces stall outputs that feed the hazard logic, which folds them into StallF/StallD/FlushE.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (range 1..15)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request; held until if_ready
- if_addr  input  AW  fetch address (PCF)
- if_rdata  output  DW  fetched instruction (InstrF); valid only when if_ready=1
- if_ready  output  1  fetch completion strobe, one cycle
- dm_req  input  1  data request; held until dm_ready
- dm_we  input  1  1=write (MemWriteM), 0=read
- dm_addr  input  AW  data address (ALUResultM)
- dm_wdata  input  DW  write data (WriteDataM)
- dm_rdata  output  DW  read data (ReadDataM); valid only when dm_ready=1
- dm_ready  output  1  data completion strobe, one cycle
- mem_valid  output  1  memory request valid
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_ready  input  1  memory accepts/completes current request
- mem_rdata  input  DW  memory read data; valid when mem_ready=1
- stall_if  output  1  if_req & ~if_ready
- stall_dm  output  1  dm_req & ~dm_ready

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- Reset (reset=0, async):
  - state=IDLE, streak counter=0.
  - mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ready=0, dm_ready=0; stall_if and stall_dm follow their requests.
- IDLE arbitration, evaluated at the clock edge:
  - dm_req and (streak<STARVE_LIMIT or !if_req) -> BUSY_DM. Latch dm_addr, dm_we and dm_wdata into the mem_* registers; mem_valid=1.
  - Otherwise, if if_req -> BUSY_IF. Latch if_addr; mem_we=0; mem_valid=1.
  - Otherwise stay IDLE with mem_valid=0.
- BUSY_x:
  - mem_valid and all mem_* registers stay stable until mem_ready=1.
  - On a cycle with mem_ready=1:
    - x_ready=1 combinationally in that same cycle.
    - x_rdata=mem_rdata combinationally.
    - Next state = IDLE; mem_valid=0 from the next cycle.
  - The non-granted ready output stays 0 throughout.
- Latency: request in IDLE at cycle 0 -> mem_valid at cycle 1 -> ready at earliest cycle 1 (zero-wait memory). Back-to-back accesses take 2 cycles each (one IDLE cycle between them).
- if_rdata and dm_rdata are don't-care when their ready is low. Drive them as mem_rdata gated to 0, so the idle value is 0.
- Streak counter (4 bits):
  - Increments when a DM grant is made while if_req=1; saturates at STARVE_LIMIT.
  - Cleared on every IF grant, and on any IDLE cycle where if_req=0.
  - When streak==STARVE_LIMIT and both requests are pending, IF wins.
- Writes: mem_we=1 only in BUSY_DM with dm_we latched as 1. dm_ready on a write means the write has committed; dm_rdata is don't-care.
- Requester withdraws req mid-transaction (pipeline flush): the transaction still completes and ready still pulses; the requester ignores it. No abort is issued on the memory bus.
- Request fields changing while BUSY have no effect; only the fields latched at grant are used.
- reset asserted mid-transaction: mem_valid drops asynchronously. Any memory response after reset is ignored. The first grant after reset release uses normal arbitration.

Test Plan:
- Single fetch, zero-wait: if_req=1, if_addr=0x100, mem_ready=1, mem_rdata=0x00500093.
  -> mem_valid=1 and mem_addr=0x100 at cycle 1; if_ready=1 and if_rdata=0x00500093 at cycle 1; stall_if=1 at cycle 0 only.
- Data write with 3 wait states: dm_req=1, dm_we=1, dm_addr=0x2004, dm_wdata=0xDEADBEEF.
  -> mem_we=1 and mem_wdata=0xDEADBEEF held for 4 cycles; dm_ready pulses once when mem_ready=1; if_ready stays 0.
- Simultaneous requests: if_req=dm_req=1 in IDLE -> data granted first. The fetch is granted in the IDLE cycle after dm_ready, and its address appears on mem_addr one cycle later.
- Starvation, STARVE_LIMIT=4: if_req held at 1 while dm_req is re-raised every slot.
  -> exactly 4 DM grants, then 1 IF grant, then DM again; streak reads 0 after the IF grant.
- Reset mid-access: reset=0 while BUSY_DM with mem_ready=0.
  -> mem_valid=0 immediately without waiting for a clock; after release with only if_req=1, the next grant is IF.
- Withdrawn fetch: if_req dropped during BUSY_IF -> if_ready still pulses on mem_ready, then the FSM returns to IDLE and grants a pending dm_req normally.
